frame_pixel_writer: RTL and testbench

- Streaming write stage feeding the 32-bit on-chip frame memory (8192 words, single-cycle writes, no waitrequest).
- Accepts 8-bit grayscale pixels from the camera/binarization pipeline with valid/ready and frame markers, and packs four pixels per word, little-endian.
- Issues one-cycle writes with byteenable at sequential word addresses from a programmable base.
- Reports completion and error status to the Nios control side.

---
 rtl/frame_pixel_writer.sv | 218 +++++++++++++++++++++
 tb/tb_frame_pixel_writer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_writer.sv
// frame_pixel_writer
// Packs a stream of 8-bit grayscale pixels into 32-bit little-endian words
// and writes them to the on-chip frame memory at sequential word addresses
// starting from a programmable base. One frame is captured per start pulse.
//
// Ports:
//   clk, reset_n         system clock (rising edge), async active-low reset
//   start                one-cycle pulse arming capture of one frame
//   base_addr            first word address, latched on accepted start
//   word_limit           max words per frame (0 = 2^ADDR_W), latched on start
//   pix_data/valid/ready pixel stream handshake
//   pix_sof, pix_eof     frame markers, qualified by pix_valid
//   mem_*                single-cycle write port (chipselect mirrors write)
//   busy                 capture in progress (waiting for sof or packing)
//   done, overflow,      sticky status, cleared by the next accepted start
//   sof_err
//   words_written        words written in the current frame

module frame_pixel_writer #(
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_limit,
   input  logic [7:0]        pix_data,
   input  logic              pix_valid,
   input  logic              pix_sof,
   input  logic              pix_eof,
   output logic              pix_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              sof_err,
   output logic [CNT_W-1:0]  words_written
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      PACK,
      FIN
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT_MAX = CNT_W'(1) << ADDR_W;

   state_t            state;
   state_t            state_nxt;

   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  limit_q;
   logic [CNT_W-1:0]  ww_q;
   logic [3:0][7:0]   asm_q;
   logic [1:0]        lanes_q;
   logic              done_pend_q;
   logic              ovf_pend_q;

   logic              start_acc;
   logic              pix_acc;
   logic              restart;
   logic              store;
   logic [1:0]        lane_sel;
   logic [3:0][7:0]   asm_nxt;
   logic [CNT_W-1:0]  ww_base;
   logic [CNT_W-1:0]  ww_inc;
   logic              word_done;
   logic              limit_hit;
   logic [3:0]        be_nxt;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, handshake and word-assembly decode
   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      busy      = 1'b0;
      start_acc = 1'b0;

      unique case (state)
         IDLE: begin
            start_acc = start;
         end
         WAIT_SOF: begin
            busy      = 1'b1;
            pix_ready = 1'b1;
         end
         PACK: begin
            busy      = 1'b1;
            pix_ready = 1'b1;
         end
         FIN: begin
            start_acc = start;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      pix_acc = pix_valid & pix_ready;

      // A sof pixel (in WAIT_SOF or mid-frame in PACK) restarts assembly
      // from lane 0 and rewinds the word index to the base address.
      restart = pix_acc & pix_sof;
      store   = pix_acc & (pix_sof | (state == PACK));

      lane_sel = restart ? 2'd0 : lanes_q;
      ww_base  = restart ? '0 : ww_q;
      ww_inc   = ww_base + CNT_W'(1);

      asm_nxt           = restart ? '0 : asm_q;
      asm_nxt[lane_sel] = pix_data;

      word_done = store & ((lane_sel == 2'd3) | pix_eof);
      limit_hit = word_done & ~pix_eof & (ww_inc == limit_q);

      unique case (lane_sel)
         2'd0:    be_nxt = 4'b0001;
         2'd1:    be_nxt = 4'b0011;
         2'd2:    be_nxt = 4'b0111;
         default: be_nxt = 4'b1111;
      endcase

      if (start_acc) begin
         state_nxt = WAIT_SOF;
      end else if (word_done && (pix_eof || limit_hit)) begin
         state_nxt = FIN;
      end else if (restart) begin
         state_nxt = PACK;
      end
   end

   // Datapath, write port and status
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q         <= '0;
         limit_q        <= '0;
         ww_q           <= '0;
         asm_q          <= '0;
         lanes_q        <= '0;
         done_pend_q    <= 1'b0;
         ovf_pend_q     <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= '0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         done           <= 1'b0;
         overflow       <= 1'b0;
         sof_err        <= 1'b0;
      end else begin
         mem_write      <= 1'b0;
         mem_chipselect <= 1'b0;

         if (start_acc) begin
            base_q      <= base_addr;
            limit_q     <= (word_limit == '0) ? LIMIT_MAX : word_limit;
            ww_q        <= '0;
            asm_q       <= '0;
            lanes_q     <= '0;
            done_pend_q <= 1'b0;
            ovf_pend_q  <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            sof_err     <= 1'b0;
         end else begin
            // Status follows the final write pulse by one cycle.
            if (done_pend_q) begin
               done        <= 1'b1;
               overflow    <= ovf_pend_q;
               done_pend_q <= 1'b0;
               ovf_pend_q  <= 1'b0;
            end

            if (restart && (state == PACK)) begin
               sof_err <= 1'b1;
            end

            if (word_done) begin
               mem_write      <= 1'b1;
               mem_chipselect <= 1'b1;
               mem_address    <= base_q + ww_base[ADDR_W-1:0];
               mem_byteenable <= be_nxt;
               mem_writedata  <= asm_nxt;
               ww_q           <= ww_inc;
               // Assembly register is freed at once so the next pixel can
               // start a fresh word while the write is on the bus.
               asm_q          <= '0;
               lanes_q        <= '0;
               if (pix_eof || limit_hit) begin
                  done_pend_q <= 1'b1;
                  ovf_pend_q  <= limit_hit;
               end
            end else if (store) begin
               asm_q   <= asm_nxt;
               lanes_q <= lane_sel + 2'd1;
               ww_q    <= ww_base;
            end
         end
      end
   end

   assign words_written = ww_q;

endmodule

// File: tb/tb_frame_pixel_writer.sv
// Testbench for frame_pixel_writer: directed scenarios with literal
// expectations, followed by randomized frames checked cycle by cycle
// against a queue-based behavioural model.

module tb_frame_pixel_writer;

   localparam int ADDR_W = 13;
   localparam int CNT_W  = 14;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  word_limit = '0;
   logic [7:0]        pix_data = '0;
   logic              pix_valid = 1'b0;
   logic              pix_sof = 1'b0;
   logic              pix_eof = 1'b0;
   logic              pix_ready;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic              busy;
   logic              done;
   logic              overflow;
   logic              sof_err;
   logic [CNT_W-1:0]  words_written;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   frame_pixel_writer #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .base_addr     (base_addr),
      .word_limit    (word_limit),
      .pix_data      (pix_data),
      .pix_valid     (pix_valid),
      .pix_sof       (pix_sof),
      .pix_eof       (pix_eof),
      .pix_ready     (pix_ready),
      .mem_address   (mem_address),
      .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect),
      .mem_write     (mem_write),
      .mem_writedata (mem_writedata),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow),
      .sof_err       (sof_err),
      .words_written (words_written)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_wait, m_pack, m_pend, m_ovfp;
   logic [12:0] m_base;
   int          m_limit, m_ww;
   logic [7:0]  cur[$];
   bit          e_write, e_ready, e_done, e_ovf, e_sofe;
   logic [12:0] e_addr;
   logic [3:0]  e_be;
   logic [31:0] e_data;

   function automatic void model_reset();
      m_wait = 0; m_pack = 0; m_pend = 0; m_ovfp = 0;
      m_base = '0; m_limit = 0; m_ww = 0;
      cur.delete();
      e_write = 0; e_ready = 0; e_done = 0; e_ovf = 0; e_sofe = 0;
      e_addr = '0; e_be = '0; e_data = '0;
   endfunction

   function automatic void model_step();
      logic [31:0] d;
      e_write = 0;
      if (start && !(m_wait || m_pack)) begin
         m_base  = base_addr;
         m_limit = (word_limit == 0) ? 8192 : int'(word_limit);
         m_ww = 0; cur.delete();
         m_pend = 0; m_ovfp = 0;
         e_done = 0; e_ovf = 0; e_sofe = 0;
         m_wait = 1;
      end else begin
         if (m_pend) begin
            e_done = 1; e_ovf = m_ovfp; m_pend = 0;
         end
         if (pix_valid && (m_wait || m_pack)) begin
            if (pix_sof) begin
               if (m_pack) e_sofe = 1;
               m_ww = 0; cur.delete();
               m_pack = 1; m_wait = 0;
            end
            if (m_pack) begin
               cur.push_back(pix_data);
               if (cur.size() == 4 || pix_eof) begin
                  d = 0;
                  foreach (cur[i]) d |= 32'(cur[i]) << (8 * i);
                  e_data  = d;
                  e_be    = 4'((1 << cur.size()) - 1);
                  e_addr  = 13'((int'(m_base) + m_ww) % 8192);
                  e_write = 1;
                  m_ww++;
                  cur.delete();
                  if (pix_eof) begin
                     m_pack = 0; m_pend = 1; m_ovfp = 0;
                  end else if (m_ww == m_limit) begin
                     m_pack = 0; m_pend = 1; m_ovfp = 1;
                  end
               end
            end
         end
      end
      e_ready = m_wait || m_pack;
   endfunction

   initial model_reset();

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step();
   end

   always @(posedge clk) cyc++;

   // ---------------- write log + per-cycle compare ----------------
   typedef struct {
      int          c;
      logic [12:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } wr_t;
   wr_t wlog[$];

   always @(negedge clk) begin
      chk("pix_ready", 32'(pix_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_ready));
      chk("done", 32'(done), 32'(e_done));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("sof_err", 32'(sof_err), 32'(e_sofe));
      chk("words_written", 32'(words_written), 32'(m_ww));
      chk("mem_write", 32'(mem_write), 32'(e_write));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(e_write));
      if (e_write) begin
         chk("mem_address", 32'(mem_address), 32'(e_addr));
         chk("mem_byteenable", 32'(mem_byteenable), 32'(e_be));
         chk("mem_writedata", mem_writedata, e_data);
      end
      if (mem_write) wlog.push_back('{cyc, mem_address, mem_writedata, mem_byteenable});
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [12:0] b, input logic [13:0] l);
      start = 1'b1; base_addr = b; word_limit = l;
      tick();
      start = 1'b0; base_addr = 13'($urandom); word_limit = 14'($urandom);
   endtask

   task automatic send(input logic [7:0] d, input bit s, input bit e);
      pix_valid = 1'b1; pix_data = d; pix_sof = s; pix_eof = e;
      tick();
      pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0; pix_data = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic chk_wr(input string name, input int idx, input logic [12:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      if (idx < wlog.size()) begin
         chk({name, "_addr"}, 32'(wlog[idx].a), 32'(a));
         chk({name, "_data"}, wlog[idx].d, d);
         chk({name, "_be"}, 32'(wlog[idx].be), 32'(be));
      end else begin
         chk({name, "_missing"}, 0, 1);
      end
   endtask

   initial begin
      int n0;
      int n;

      #2 reset_n = 1'b0;
      tick();
      chk("rst_pix_ready", 32'(pix_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_words", 32'(words_written), 0);
      reset_n = 1'b1;
      idle(2);

      // Full words, back-to-back
      n0 = wlog.size();
      do_start(13'h0100, 14'd16);
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i), i == 0, i == 7);
      idle(3);
      chk("t1_nwrites", wlog.size() - n0, 2);
      chk_wr("t1_w0", n0, 13'h0100, 32'h13121110, 4'hF);
      chk_wr("t1_w1", n0 + 1, 13'h0101, 32'h17161514, 4'hF);
      if (wlog.size() >= n0 + 2) chk("t1_spacing", wlog[n0+1].c - wlog[n0].c, 4);
      chk("t1_done", 32'(done), 1);
      chk("t1_words", 32'(words_written), 2);
      chk("t1_ovf", 32'(overflow), 0);

      // Partial final word
      n0 = wlog.size();
      do_start(13'h0200, 14'd16);
      for (int i = 0; i < 6; i++) send(8'(8'h20 + i), i == 0, i == 5);
      idle(3);
      chk("t2_nwrites", wlog.size() - n0, 2);
      chk_wr("t2_w1", n0 + 1, 13'h0201, 32'h00002524, 4'h3);
      chk("t2_done", 32'(done), 1);

      // Overflow at limit 1
      n0 = wlog.size();
      do_start(13'h0300, 14'd1);
      for (int i = 0; i < 4; i++) send(8'(8'h30 + i), i == 0, 1'b0);
      chk("t3_ready_write_cycle", 32'(pix_ready), 0);
      for (int i = 4; i < 8; i++) send(8'(8'h30 + i), 1'b0, 1'b0);
      idle(2);
      chk("t3_nwrites", wlog.size() - n0, 1);
      chk_wr("t3_w0", n0, 13'h0300, 32'h33323130, 4'hF);
      chk("t3_ovf", 32'(overflow), 1);
      chk("t3_done", 32'(done), 1);
      chk("t3_ready", 32'(pix_ready), 0);

      // Address wrap, limit 0 meaning full memory
      n0 = wlog.size();
      do_start(13'h1FFF, 14'd0);
      for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), i == 0, i == 7);
      idle(3);
      chk_wr("t4_w0", n0, 13'h1FFF, 32'hA3A2A1A0, 4'hF);
      chk_wr("t4_w1", n0 + 1, 13'h0000, 32'hA7A6A5A4, 4'hF);

      // Sof handling; a start while busy is ignored
      n0 = wlog.size();
      do_start(13'h0040, 14'd16);
      for (int i = 0; i < 3; i++) send(8'h01, 1'b0, 1'b0);
      do_start(13'h0999, 14'd1);
      chk("t5_discard", wlog.size() - n0, 0);
      send(8'h50, 1'b1, 1'b0);
      send(8'h51, 1'b0, 1'b0);
      send(8'h52, 1'b0, 1'b0);
      send(8'h60, 1'b1, 1'b0);
      chk("t5_sof_err", 32'(sof_err), 1);
      chk("t5_nowrite", wlog.size() - n0, 0);
      send(8'h61, 1'b0, 1'b0);
      send(8'h62, 1'b0, 1'b0);
      send(8'h63, 1'b0, 1'b0);
      send(8'h64, 1'b0, 1'b1);
      idle(3);
      chk_wr("t5_w0", n0, 13'h0040, 32'h63626160, 4'hF);
      chk_wr("t5_w1", n0 + 1, 13'h0041, 32'h00000064, 4'h1);
      chk("t5_words", 32'(words_written), 2);

      // sof and eof on the same pixel
      n0 = wlog.size();
      do_start(13'h0500, 14'd16);
      send(8'h77, 1'b1, 1'b1);
      idle(3);
      chk("t6_nwrites", wlog.size() - n0, 1);
      chk_wr("t6_w0", n0, 13'h0500, 32'h00000077, 4'h1);

      // Reset mid-frame
      do_start(13'h0080, 14'd16);
      send(8'h90, 1'b1, 1'b0);
      send(8'h91, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("t7_ready", 32'(pix_ready), 0);
      chk("t7_busy", 32'(busy), 0);
      chk("t7_words", 32'(words_written), 0);
      chk("t7_sof_err", 32'(sof_err), 0);
      tick();
      reset_n = 1'b1;
      tick();
      n0 = wlog.size();
      pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'h92;
      #1;
      chk("t7_refused", 32'(pix_ready), 0);
      tick();
      for (int i = 0; i < 4; i++) send(8'(8'h93 + i), 1'b0, i == 3);
      idle(2);
      chk("t7_nowrites", wlog.size() - n0, 0);

      // Randomized frames
      for (int f = 0; f < 80; f++) begin
         do_start(13'($urandom),
                  ($urandom_range(0, 3) == 0) ? 14'd0 : 14'($urandom_range(1, 6)));
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) begin
            pix_valid  = ($urandom_range(0, 3) != 0);
            pix_data   = 8'($urandom);
            pix_sof    = (i == 0) || ($urandom_range(0, 9) == 0);
            pix_eof    = ($urandom_range(0, 11) == 0);
            start      = ($urandom_range(0, 19) == 0);
            base_addr  = 13'($urandom);
            word_limit = 14'($urandom_range(0, 5));
            reset_n    = ($urandom_range(0, 249) != 0);
            tick();
         end
         pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
         start = 1'b0; reset_n = 1'b1;
         idle(2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
